uart_hex_io_handler: RTL

- Parametrised ASCII-hex framing engine for the UART host link; next generation of the uart io handler.
- Decoupled from the phy: consumes and produces raw bytes over a strobe/valid-ready interface, so any serial phy can drive it.
- Generic data word width and count width; accepts lower-case hex; resyncs on bad characters with an error pulse.
- Fetches outgoing words one at a time via a request strobe, so a multi-word reply needs no external latching.

---
 rtl/uart_hex_io_pkg.sv | 44 ++++
 rtl/uart_hex_tx_serializer.sv | 142 ++++++++++++++
 rtl/uart_hex_io_handler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_io_pkg.sv
// Shared state encodings, character constants and hex conversion helpers for the hex framing engine.
// Build option HEX_IO_CHECKSUM_EN adds the checksum states to both FSM encodings.
package uart_hex_io_pkg;

  localparam logic [7:0] SOF_IN_CHAR  = 8'h4C;
  localparam logic [7:0] SOF_OUT_CHAR = 8'h53;
  localparam logic [7:0] CHAR_0       = 8'h30;
  localparam logic [7:0] CHAR_9       = 8'h39;
  localparam logic [7:0] CHAR_UA      = 8'h41;
  localparam logic [7:0] CHAR_UF      = 8'h46;
  localparam logic [7:0] CHAR_LA      = 8'h61;
  localparam logic [7:0] CHAR_LF      = 8'h66;

  typedef enum logic [2:0] {
    RX_IDLE, RX_COUNT, RX_COMMAND, RX_ADDRESS, RX_DATA
`ifdef HEX_IO_CHECKSUM_EN
    , RX_CSUM
`endif
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SOF, TX_STATUS, TX_ADDRESS, TX_DATA,
`ifdef HEX_IO_CHECKSUM_EN
    TX_CSUM,
`endif
    TX_DONE
  } tx_state_t;

  // Returns {valid, nibble}; both letter cases are accepted.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= CHAR_0 && c <= CHAR_9)
      r = {1'b1, c[3:0]};
    else if ((c >= CHAR_UA && c <= CHAR_UF) || (c >= CHAR_LA && c <= CHAR_LF))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (CHAR_0 + {4'd0, n}) : (CHAR_UA - 8'd10 + {4'd0, n});
  endfunction

endpackage

// File: rtl/uart_hex_tx_serializer.sv
// Outbound frame serializer: SOF, status, address and data words as upper-case hex over valid/ready.
// With HEX_IO_CHECKSUM_EN two XOR checksum characters close the frame.
module uart_hex_tx_serializer
  import uart_hex_io_pkg::*;
#(
  parameter int         DATA_WIDTH  = 32,
  parameter int         COUNT_WIDTH = 28,
  parameter logic [7:0] SOF_OUT     = SOF_OUT_CHAR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   oh_en,
  input  logic [31:0]            out_status,
  input  logic [31:0]            out_address,
  input  logic [DATA_WIDTH-1:0]  out_data,
  input  logic [COUNT_WIDTH-1:0] out_data_count,
  input  logic                   tx_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  output logic                   oh_ready,
  output logic                   oh_data_req,
  output logic                   oh_finished
);
  localparam logic [4:0] LAST_DATA = 5'(DATA_WIDTH / 4 - 1);

  tx_state_t              r_state, w_next;
  logic [4:0]             r_nib;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [31:0]            r_status, r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   w_last, w_acc, w_start;
`ifdef HEX_IO_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  assign w_acc   = tx_valid & tx_ready;
  assign w_start = (r_state == TX_IDLE) & oh_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_next;
  end

  // tx_byte is derived only from registers, so it holds steady while stalled
  always_comb begin
    w_next      = r_state;
    tx_valid    = 1'b0;
    tx_byte     = 8'd0;
    oh_ready    = 1'b0;
    oh_data_req = 1'b0;
    oh_finished = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        oh_ready = 1'b1;
        if (oh_en) begin
          oh_data_req = 1'b1;
          w_next      = TX_SOF;
        end
      end
      TX_SOF: begin
        tx_valid = 1'b1;
        tx_byte  = SOF_OUT;
        w_last   = 1'b1;
        if (tx_ready) w_next = TX_STATUS;
      end
      TX_STATUS: begin
        tx_valid = 1'b1;
        tx_byte  = nib_to_hex(r_status[31:28]);
        w_last   = (r_nib == 5'd7);
        if (tx_ready && w_last) w_next = TX_ADDRESS;
      end
      TX_ADDRESS: begin
        tx_valid = 1'b1;
        tx_byte  = nib_to_hex(r_addr[31:28]);
        w_last   = (r_nib == 5'd7);
        if (tx_ready && w_last) w_next = TX_DATA;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_byte  = nib_to_hex(r_data[DATA_WIDTH-1 -: 4]);
        w_last   = (r_nib == LAST_DATA);
        if (tx_ready && w_last) begin
          if (r_cnt != '0) oh_data_req = 1'b1;
`ifdef HEX_IO_CHECKSUM_EN
          else             w_next = TX_CSUM;
`else
          else             w_next = TX_DONE;
`endif
        end
      end
`ifdef HEX_IO_CHECKSUM_EN
      TX_CSUM: begin
        tx_valid = 1'b1;
        tx_byte  = nib_to_hex(r_nib[0] ? r_csum[3:0] : r_csum[7:4]);
        w_last   = (r_nib == 5'd1);
        if (tx_ready && w_last) w_next = TX_DONE;
      end
`endif
      TX_DONE: begin
        oh_finished = 1'b1;
        w_next      = TX_IDLE;
      end
      default: w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nib  <= '0;
      r_cnt  <= '0;
`ifdef HEX_IO_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (w_start) begin
      r_nib  <= '0;
      r_cnt  <= out_data_count;
`ifdef HEX_IO_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (w_acc) begin
      r_nib <= w_last ? 5'd0 : r_nib + 5'd1;
      if (r_state == TX_DATA && w_last && r_cnt != '0) r_cnt <= r_cnt - COUNT_WIDTH'(1);
`ifdef HEX_IO_CHECKSUM_EN
      if (r_state != TX_CSUM) r_csum <= r_csum ^ tx_byte;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (oh_data_req)                      r_data <= out_data;
    else if (w_acc && r_state == TX_DATA) r_data <= r_data << 4;
    if (w_start) begin
      r_status <= out_status;
      r_addr   <= out_address;
    end else if (w_acc) begin
      if (r_state == TX_STATUS)  r_status <= r_status << 4;
      if (r_state == TX_ADDRESS) r_addr   <= r_addr << 4;
    end
  end

endmodule

// File: rtl/uart_hex_io_handler.sv
// ASCII-hex framing engine: decodes inbound 'L' frames into command/address/data words and serializes replies.
// HEX_IO_CHECKSUM_EN appends/validates a two-character XOR checksum on every frame.
module uart_hex_io_handler
  import uart_hex_io_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         COUNT_NIBBLES = 7,
  parameter logic [7:0] SOF_IN        = SOF_IN_CHAR,
  parameter logic [7:0] SOF_OUT       = SOF_OUT_CHAR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         ih_ready,
  output logic                         ih_frame_ok,
  output logic                         ih_error,
  output logic [31:0]                  in_command,
  output logic [31:0]                  in_address,
  output logic [DATA_WIDTH-1:0]        in_data,
  output logic [4*COUNT_NIBBLES-1:0]   in_data_count,
  output logic                         oh_ready,
  input  logic                         oh_en,
  output logic                         oh_data_req,
  output logic                         oh_finished,
  input  logic [31:0]                  out_status,
  input  logic [31:0]                  out_address,
  input  logic [DATA_WIDTH-1:0]        out_data,
  input  logic [4*COUNT_NIBBLES-1:0]   out_data_count
);
  localparam int         COUNT_WIDTH = 4 * COUNT_NIBBLES;
  localparam int         SH_W0       = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam int         SH_W        = (SH_W0 > COUNT_WIDTH) ? SH_W0 : COUNT_WIDTH;
  localparam logic [4:0] LAST_COUNT  = 5'(COUNT_NIBBLES - 1);
  localparam logic [4:0] LAST_DATA   = 5'(DATA_WIDTH / 4 - 1);

  rx_state_t              r_rx_state, w_rx_next;
  logic [SH_W-1:0]        r_shift, w_shift_nx;
  logic [4:0]             r_nib;
  logic [COUNT_WIDTH-1:0] r_rem;
  logic [4:0]             w_hex;
  logic                   w_sof, w_bad, w_take, w_last;
`ifdef HEX_IO_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  assign w_hex      = hex_to_nib(rx_byte);
  assign w_sof      = rx_valid && (rx_byte == SOF_IN);
  assign w_bad      = rx_valid && (r_rx_state != RX_IDLE) && !w_sof && !w_hex[4];
  assign w_take     = rx_valid && (r_rx_state != RX_IDLE) && !w_sof && w_hex[4];
  assign w_shift_nx = (r_shift << 4) | SH_W'(w_hex[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_last = 1'b0;
    case (r_rx_state)
      RX_COUNT:               w_last = (r_nib == LAST_COUNT);
      RX_COMMAND, RX_ADDRESS: w_last = (r_nib == 5'd7);
      RX_DATA:                w_last = (r_nib == LAST_DATA);
`ifdef HEX_IO_CHECKSUM_EN
      RX_CSUM:                w_last = (r_nib == 5'd1);
`endif
      default:                w_last = 1'b0;
    endcase
  end

  // SOF from any state restarts the frame; a bad hex char aborts it
  always_comb begin
    w_rx_next = r_rx_state;
    if (w_sof)
      w_rx_next = RX_COUNT;
    else if (w_bad)
      w_rx_next = RX_IDLE;
    else if (w_take && w_last) begin
      case (r_rx_state)
        RX_COUNT:   w_rx_next = RX_COMMAND;
        RX_COMMAND: w_rx_next = RX_ADDRESS;
        RX_ADDRESS: w_rx_next = RX_DATA;
        RX_DATA: begin
          if (r_rem == '0)
`ifdef HEX_IO_CHECKSUM_EN
            w_rx_next = RX_CSUM;
`else
            w_rx_next = RX_IDLE;
`endif
        end
        default:    w_rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_sof)       r_shift <= '0;
    else if (w_take) r_shift <= w_shift_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nib         <= '0;
      r_rem         <= '0;
      in_command    <= '0;
      in_address    <= '0;
      in_data       <= '0;
      in_data_count <= '0;
      ih_ready      <= 1'b0;
      ih_frame_ok   <= 1'b0;
      ih_error      <= 1'b0;
`ifdef HEX_IO_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      ih_ready    <= 1'b0;
      ih_frame_ok <= 1'b0;
      ih_error    <= 1'b0;
      if (w_sof) begin
        r_nib  <= '0;
`ifdef HEX_IO_CHECKSUM_EN
        r_csum <= SOF_IN;
`endif
      end else if (w_bad) begin
        ih_error <= 1'b1;
      end else if (w_take) begin
        r_nib <= w_last ? 5'd0 : r_nib + 5'd1;
`ifdef HEX_IO_CHECKSUM_EN
        if (r_rx_state != RX_CSUM) r_csum <= r_csum ^ rx_byte;
`endif
        if (w_last) begin
          case (r_rx_state)
            RX_COUNT:   r_rem      <= w_shift_nx[COUNT_WIDTH-1:0];
            RX_COMMAND: in_command <= w_shift_nx[31:0];
            RX_ADDRESS: in_address <= w_shift_nx[31:0];
            RX_DATA: begin
              in_data       <= w_shift_nx[DATA_WIDTH-1:0];
              in_data_count <= r_rem;
              ih_ready      <= 1'b1;
              if (r_rem != '0) r_rem <= r_rem - COUNT_WIDTH'(1);
`ifndef HEX_IO_CHECKSUM_EN
              if (r_rem == '0) ih_frame_ok <= 1'b1;
`endif
            end
`ifdef HEX_IO_CHECKSUM_EN
            RX_CSUM: begin
              if ({r_shift[3:0], w_hex[3:0]} == r_csum) ih_frame_ok <= 1'b1;
              else                                      ih_error    <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  uart_hex_tx_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH),
    .SOF_OUT     (SOF_OUT)
  ) u_tx (
    .clk            (clk),
    .rst            (rst),
    .oh_en          (oh_en),
    .out_status     (out_status),
    .out_address    (out_address),
    .out_data       (out_data),
    .out_data_count (out_data_count),
    .tx_ready       (tx_ready),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .oh_ready       (oh_ready),
    .oh_data_req    (oh_data_req),
    .oh_finished    (oh_finished)
  );

endmodule
